// File: rtl/add_share_arb_pkg.sv
// Shared arithmetic configuration types and round-robin helper
// for the accumulation-path adder sharing logic.
package arith_pckg;

    typedef enum logic [1:0] {
        FIXED_POINT_GENERIC,
        FLOATING_POINT_GENERIC
    } arith_type_t;

    typedef struct packed {
        int unsigned int_wdt;
        int unsigned frac_wdt;
    } fxp_cfg_t;

    typedef struct packed {
        int unsigned word_wdt;
        fxp_cfg_t    fxp_cfg;
        arith_type_t arith_type;
        logic        arith_satur;
    } arith_cfg_t;

    localparam int RR_MAX = 16;
    localparam int RR_IW  = 4;

    // Widest tag form; modules narrow idx to $clog2 of their requester count.
    typedef struct packed {
        logic             v;
        logic [RR_IW-1:0] idx;
    } add_req_tag_t;

    function automatic logic [RR_IW-1:0] rr_next(
        input logic [RR_MAX-1:0] req,
        input logic [RR_IW-1:0]  ptr,
        input int                n
    );
        logic [RR_IW-1:0] res;
        logic             hit;
        int               idx;
        res = ptr;
        hit = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            idx = (int'(ptr) + k) % n;
            if (!hit && k <= n && req[idx[RR_IW-1:0]]) begin
                res = idx[RR_IW-1:0];
                hit = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/add_share_arb_if.sv
// Requester-side handshake and shared-adder bus of add_share_arb.
// slave is the arbiter view, master the requester/adder view.
interface add_share_arb_if #(
    parameter int N_REQ = 4,
    parameter int W     = 16
);
    logic [N_REQ-1:0]   req_val;
    logic [N_REQ-1:0]   req_rdy;
    logic [N_REQ*W-1:0] req_op_a;
    logic [N_REQ*W-1:0] req_op_b;
    logic [W-1:0]       rsp_res;
    logic [N_REQ-1:0]   rsp_val;
    logic [W-1:0]       add_op_a;
    logic [W-1:0]       add_op_b;
    logic               add_op_val;
    logic [W-1:0]       add_res;
    logic               add_res_val;

    modport slave (
        input  req_val, req_op_a, req_op_b,
        input  add_res, add_res_val,
        output req_rdy, rsp_res, rsp_val,
        output add_op_a, add_op_b, add_op_val
    );

    modport master (
        output req_val, req_op_a, req_op_b,
        output add_res, add_res_val,
        input  req_rdy, rsp_res, rsp_val,
        input  add_op_a, add_op_b, add_op_val
    );

endinterface

// File: rtl/add_share_arb_rr_arbiter.sv
// Combinational round-robin grant search starting after ptr.
// The pointer register itself lives in the parent.
module rr_arbiter
    import arith_pckg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_idx
);

    assign gnt_idx = IW'(rr_next(RR_MAX'(req), RR_IW'(ptr), N_REQ));

    always_comb begin
        gnt = '0;
        if (|req) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/add_share_arb.sv
// Shares one pipelined adder among N_REQ requesters; a tag pipeline
// matched to the adder latency routes each result to its issuer.
module add_share_arb
    import arith_pckg::*;
#(
    parameter arith_cfg_t ADD_ARITH_CFG = '{
        word_wdt:   16,
        fxp_cfg:    '{int_wdt: 8, frac_wdt: 8},
        arith_type: FIXED_POINT_GENERIC,
        arith_satur: 1'b1
    },
    parameter int N_REQ   = 4,
    parameter int ADD_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clk_en,
    add_share_arb_if.slave bus,
    output logic           busy,
    output logic           lat_err
);

    localparam int W  = int'(ADD_ARITH_CFG.word_wdt);
    localparam int IW = $clog2(N_REQ);

    typedef struct packed {
        logic          v;
        logic [IW-1:0] idx;
    } tag_t;

    logic [IW-1:0]    ptr;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             en;
    logic             xfer;
    logic             mismatch;
    tag_t             tag_in;
    tag_t             tag_out;
    tag_t             tag_q [ADD_LAT];

    rr_arbiter #(
        .N_REQ(N_REQ),
        .IW   (IW)
    ) u_rr (
        .req    (bus.req_val),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    // Grants are also held off while reset is asserted.
    assign en          = clk_en & rst_n;
    assign xfer        = en & (|bus.req_val);
    assign bus.req_rdy = en ? gnt : '0;

    always_comb begin
        bus.add_op_val = xfer;
        bus.add_op_a   = '0;
        bus.add_op_b   = '0;
        tag_in         = '0;
        if (xfer) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt[i]) begin
                    bus.add_op_a = bus.req_op_a[i*W +: W];
                    bus.add_op_b = bus.req_op_b[i*W +: W];
                end
            end
            tag_in.v   = 1'b1;
            tag_in.idx = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IW'(N_REQ - 1);
        end else if (xfer) begin
            ptr <= gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ADD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else if (clk_en) begin
            tag_q[0] <= tag_in;
            for (int k = 1; k < ADD_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign tag_out  = tag_q[ADD_LAT-1];
    assign mismatch = tag_out.v != bus.add_res_val;

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < ADD_LAT; k++) begin
            busy = busy | tag_q[k].v;
        end
    end

    assign bus.rsp_res = bus.add_res;

    always_comb begin
        bus.rsp_val = '0;
        if (tag_out.v && bus.add_res_val) begin
            bus.rsp_val[tag_out.idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_err <= 1'b0;
        end else if (clk_en && mismatch) begin
            lat_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_add_share_arb.sv
// Randomized and directed bench for add_share_arb with a behavioural
// saturating Q8.8 adder and a slot-scheduled response model.
module tb_add_share_arb;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic clk_en;
    logic busy;
    logic lat_err;

    add_share_arb_if #(.N_REQ(N), .W(W)) bus ();

    add_share_arb #(
        .N_REQ  (N),
        .ADD_LAT(LAT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .bus    (bus),
        .busy   (busy),
        .lat_err(lat_err)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat_add(input logic [15:0] x,
                                            input logic [15:0] y);
        int s;
        s = int'($signed(x)) + int'($signed(y));
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    // behavioural shared adder, not reset by rst_n
    logic        adder_clr;
    logic        inj;
    logic        ap_v   [LAT];
    logic [15:0] ap_res [LAT];

    always @(posedge clk) begin
        if (adder_clr) begin
            for (int k = 0; k < LAT; k++) begin
                ap_v[k]   <= 1'b0;
                ap_res[k] <= '0;
            end
        end else if (clk_en) begin
            ap_v[0]   <= bus.add_op_val;
            ap_res[0] <= sat_add(bus.add_op_a, bus.add_op_b);
            for (int k = 1; k < LAT; k++) begin
                ap_v[k]   <= ap_v[k-1];
                ap_res[k] <= ap_res[k-1];
            end
        end
    end

    assign bus.add_res     = ap_res[LAT-1];
    assign bus.add_res_val = ap_v[LAT-1] | inj;

    // requester state
    logic        val [N];
    logic [15:0] a   [N];
    logic [15:0] b   [N];

    // reference model: result slots indexed by enabled-cycle count
    int          m_ptr;
    int          ec;
    logic        m_lat_err;
    logic        sv   [256];
    int          sidx [256];
    logic [15:0] sres [256];
    int          m_gnt;
    int          o_gnt;

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_val[i]          = val[i];
            bus.req_op_a[i*W +: W]  = a[i];
            bus.req_op_b[i*W +: W]  = b[i];
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 256; k++) begin
            sv[k]   = 1'b0;
            sidx[k] = 0;
            sres[k] = '0;
        end
        m_ptr     = N - 1;
        ec        = 0;
        m_lat_err = 1'b0;
    endtask

    task automatic tick();
        int          gi;
        int          i;
        int          s;
        int          slot;
        logic [3:0]  erdy;
        logic [3:0]  ersp;
        logic        eb;
        #2;
        gi = -1;
        if (clk_en && rst_n) begin
            for (int k = 1; k <= N; k++) begin
                i = (m_ptr + k) % N;
                if (gi < 0 && val[i]) gi = i;
            end
        end
        erdy = '0;
        if (gi >= 0) erdy[gi] = 1'b1;
        chk("req_rdy", bus.req_rdy, erdy);
        chk("add_op_val", bus.add_op_val, gi >= 0);
        chk("add_op_a", bus.add_op_a, (gi >= 0) ? a[gi] : 16'h0);
        chk("add_op_b", bus.add_op_b, (gi >= 0) ? b[gi] : 16'h0);
        s    = ec % 256;
        ersp = '0;
        if (sv[s]) ersp[sidx[s]] = 1'b1;
        chk("rsp_val", bus.rsp_val, ersp);
        if (sv[s]) chk("rsp_res", bus.rsp_res, sres[s]);
        eb = 1'b0;
        for (int k = 0; k < LAT; k++) eb = eb | sv[(ec + k) % 256];
        chk("busy", busy, eb);
        chk("lat_err", lat_err, m_lat_err);
        m_gnt = gi;
        o_gnt = -1;
        for (int k = 0; k < N; k++) if (bus.req_rdy[k]) o_gnt = k;
        @(posedge clk);
        if (rst_n && clk_en) begin
            if (gi >= 0) begin
                slot       = (ec + LAT) % 256;
                sv[slot]   = 1'b1;
                sidx[slot] = gi;
                sres[slot] = sat_add(a[gi], b[gi]);
                m_ptr      = gi;
            end
            sv[ec % 256] = 1'b0;
            ec++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < N; i++) val[i] = 1'b0;
        apply();
        repeat (n) tick();
    endtask

    task automatic do_reset();
        clk_en = 1'b1;
        inj    = 1'b0;
        idle(LAT + 1);
        rst_n = 1'b0;
        model_clear();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (!val[i] || m_gnt == i) begin
                val[i] = ($urandom_range(0, 2) != 0);
                a[i]   = 16'($urandom);
                b[i]   = 16'($urandom);
            end
        end
        apply();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        clk_en    = 1'b1;
        inj       = 1'b0;
        adder_clr = 1'b1;
        for (int i = 0; i < N; i++) begin
            val[i] = 1'b0;
            a[i]   = '0;
            b[i]   = '0;
        end
        apply();
        model_clear();
        @(negedge clk);
        tick();
        adder_clr = 1'b0;
        tick();
        rst_n = 1'b1;

        // single request from requester 2
        val[2] = 1'b1; a[2] = 16'h0180; b[2] = 16'h0080;
        apply();
        tick();
        idle(1);
        chk("single_val", bus.rsp_val, 4'b0100);
        chk("single_res", bus.rsp_res, 16'h0200);
        idle(LAT);

        // fairness from reset: all requesters held valid
        do_reset();
        for (int i = 0; i < N; i++) val[i] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            apply();
            tick();
            chk("rr_order", o_gnt, k % N);
            a[k % N] = 16'($urandom);
            b[k % N] = 16'($urandom);
        end
        idle(LAT + 1);

        // saturation passes straight through
        val[1] = 1'b1; a[1] = 16'h7F00; b[1] = 16'h0200;
        apply();
        tick();
        idle(1);
        chk("sat_val", bus.rsp_val, 4'b0010);
        chk("sat_res", bus.rsp_res, 16'h7FFF);
        idle(LAT);

        // clock-enable freeze with another requester waiting
        val[3] = 1'b1; a[3] = 16'h1234; b[3] = 16'h0101;
        apply();
        tick();
        val[3] = 1'b0; val[0] = 1'b1; a[0] = 16'h0001; b[0] = 16'h0002;
        apply();
        clk_en = 1'b0;
        repeat (3) tick();
        clk_en = 1'b1;
        tick();
        chk("freeze_val", bus.rsp_val, 4'b1000);
        chk("freeze_res", bus.rsp_res, 16'h1335);
        idle(LAT + 1);

        // randomized traffic with clock-enable gaps and held operands
        m_gnt = -1;
        for (int c = 0; c < 400; c++) begin
            clk_en = ($urandom_range(0, 9) != 0);
            refresh();
            tick();
        end
        clk_en = 1'b1;
        idle(LAT + 1);

        // adder valid one cycle early
        val[1] = 1'b1; a[1] = 16'h0010; b[1] = 16'h0020;
        apply();
        tick();
        val[1] = 1'b0;
        apply();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        m_lat_err = 1'b1;
        repeat (4) tick();

        // reset one cycle after issue discards the in-flight tag
        do_reset();
        val[2] = 1'b1; a[2] = 16'h0100; b[2] = 16'h0100;
        apply();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_err", lat_err, 1'b0);
        model_clear();
        for (int i = 0; i < N; i++) val[i] = 1'b1;
        apply();
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_first_gnt", o_gnt, 0);
        m_lat_err = 1'b1;
        idle(LAT + 2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
